// File: rtl/mdu_core_pkg.sv
// Shared MDOp encodings, FSM states and op-class helpers for the multiply/divide unit.
// Defining MDU_MADD_EN makes MADD/MADDU launch accumulate ops; otherwise those codes are no-ops.
package mdu_core_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10
  } mdop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int CNT_W = 4;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  function automatic logic is_madd_op(logic [3:0] op);
    return MADD_EN && ((op == MD_MADD) || (op == MD_MADDU));
  endfunction

  function automatic logic is_mul_op(logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || is_madd_op(op);
  endfunction

  function automatic logic is_div_op(logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core_if.sv
// E-stage <-> multiply/divide unit bundle: operands and op code in, Start/Busy and HI/LO/MDOut back.
interface mdu_core_if;
  logic        Req;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  modport master (
    output Req, MDOp, A, B,
    input  Start, Busy, HI, LO, MDOut
  );

  modport slave (
    input  Req, MDOp, A, B,
    output Start, Busy, HI, LO, MDOut
  );
endinterface

// File: rtl/mdu_core_arith.sv
// Combinational 32x32 multiply and divide producing the 64-bit {hi,lo} result for one MDOp.
// Division works on magnitudes so that 0x80000000 / -1 wraps to 0x80000000 without overflow.
module mdu_arith
  import mdu_core_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div_by_zero
);

  logic        w_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_product;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_divisor;
  logic [31:0] w_quot_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  always_comb begin
    w_signed  = (i_op == MD_MULT) || (i_op == MD_DIV) || (i_op == MD_MADD);
    w_a_ext   = w_signed ? {{32{i_a[31]}}, i_a} : {32'd0, i_a};
    w_b_ext   = w_signed ? {{32{i_b[31]}}, i_b} : {32'd0, i_b};
    w_product = w_a_ext * w_b_ext;

    w_a_neg    = w_signed && i_a[31];
    w_b_neg    = w_signed && i_b[31];
    w_a_mag    = w_a_neg ? (~i_a + 32'd1) : i_a;
    w_b_mag    = w_b_neg ? (~i_b + 32'd1) : i_b;
    // A zero divisor is replaced so the divider never sees x/0; the result is discarded anyway.
    w_divisor  = (i_b == 32'd0) ? 32'd1 : w_b_mag;
    w_quot_mag = w_a_mag / w_divisor;
    w_rem_mag  = w_a_mag % w_divisor;
    w_quot     = (w_a_neg ^ w_b_neg) ? (~w_quot_mag + 32'd1) : w_quot_mag;
    w_rem      = w_a_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;

    o_div_by_zero = is_div_op(i_op) && (i_b == 32'd0);
    o_result      = is_div_op(i_op) ? {w_rem, w_quot} : w_product;
  end

endmodule

// File: rtl/mdu_core.sv
// Multiply/divide unit for the E stage: fixed-latency mult/div with Start/Busy handshake and HI/LO ownership.
// MDU_MADD_EN (see mdu_core_pkg) adds MADD/MADDU accumulation into HI/LO at retire.
module mdu_core
  import mdu_core_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_core_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_skip;
  logic             r_pend_acc;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0]      w_result;
  logic             w_div_by_zero;
  logic             w_launch_op;
  logic             w_start;
  logic             w_retire;
  logic             w_mt_ok;

  mdu_arith u_arith (
    .i_op          (bus.MDOp),
    .i_a           (bus.A),
    .i_b           (bus.B),
    .o_result      (w_result),
    .o_div_by_zero (w_div_by_zero)
  );

  assign w_launch_op = is_mul_op(bus.MDOp) || is_div_op(bus.MDOp);
  assign w_start     = w_launch_op && !bus.Req && (r_state == ST_IDLE);
  assign w_retire    = (r_state == ST_BUSY) && (r_count == CNT_W'(1));
  assign w_mt_ok     = !bus.Req && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start)  w_next_state = ST_BUSY;
      ST_BUSY: if (w_retire) w_next_state = ST_IDLE;
      default:               w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.Start = w_start;
    bus.Busy  = (r_state == ST_BUSY);
    bus.HI    = r_hi;
    bus.LO    = r_lo;
    bus.MDOut = 32'd0;
    if (bus.MDOp == MD_MFHI) bus.MDOut = r_hi;
    if (bus.MDOp == MD_MFLO) bus.MDOut = r_lo;
  end

  // The result is computed at launch and held; an in-flight op retires even if Req is raised later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_pend_hi   <= '0;
      r_pend_lo   <= '0;
      r_pend_skip <= 1'b0;
      r_pend_acc  <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      if (w_start) begin
        r_count                <= is_div_op(bus.MDOp) ? DIV_LOAD : MULT_LOAD;
        {r_pend_hi, r_pend_lo} <= w_result;
        r_pend_skip            <= w_div_by_zero;
        r_pend_acc             <= is_madd_op(bus.MDOp);
      end else if (r_state == ST_BUSY) begin
        r_count <= r_count - CNT_W'(1);
      end

      if (w_retire) begin
        if (!r_pend_skip) begin
          if (r_pend_acc) begin
            {r_hi, r_lo} <= {r_hi, r_lo} + {r_pend_hi, r_pend_lo};
          end else begin
            {r_hi, r_lo} <= {r_pend_hi, r_pend_lo};
          end
        end
      end else if (w_mt_ok) begin
        if (bus.MDOp == MD_MTHI) r_hi <= bus.A;
        if (bus.MDOp == MD_MTLO) r_lo <= bus.A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: directed scenarios plus randomized ops against an arithmetic model of HI/LO.
// Expectations for MADD/MADDU follow MDU_MADD_EN.
module tb_mdu_core;
  import mdu_core_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

`ifdef MDU_MADD_EN
  localparam bit maddEn = 1'b1;
`else
  localparam bit maddEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  mdu_core_if bus ();

  mdu_core #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: what HI/LO should hold once an accepted op has fully taken effect.
  function automatic void model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  {mHi, mLo} = sa * sb;
      MD_MULTU: {mHi, mLo} = ua * ub;
      MD_DIV:   if (b != 32'd0) begin mLo = 32'(sa / sb); mHi = 32'(sa % sb); end
      MD_DIVU:  if (b != 32'd0) begin mLo = 32'(ua / ub); mHi = 32'(ua % ub); end
      MD_MADD:  if (maddEn) {mHi, mLo} = {mHi, mLo} + 64'(sa * sb);
      MD_MADDU: if (maddEn) {mHi, mLo} = {mHi, mLo} + ua * ub;
      MD_MTHI:  mHi = a;
      MD_MTLO:  mLo = a;
      default:  ;
    endcase
  endfunction

  function automatic bit launches(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU) ||
           (maddEn && ((op == MD_MADD) || (op == MD_MADDU)));
  endfunction

  function automatic int op_cycles(input logic [3:0] op);
    return ((op == MD_DIV) || (op == MD_DIVU)) ? DIV_N : MULT_N;
  endfunction

  function automatic bit protocol_class(input logic [3:0] op);
    return ((op >= MD_MULT) && (op <= MD_MTLO)) || (op == MD_MADD) || (op == MD_MADDU);
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    bus.MDOp = op;
    bus.A    = a;
    bus.B    = b;
    bus.Req  = req;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
    drive(MD_MTHI, hi, 32'd0, 1'b0);
    tick();
    drive(MD_MTLO, lo, 32'd0, 1'b0);
    tick();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    mHi = hi;
    mLo = lo;
  endtask

  // Any mult/div/mt* request while Busy violates the hazard unit's guarantee.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.Busy === 1'b1 && protocol_class(bus.MDOp)) begin
      errors++;
      $display("[TB] FAIL protocol op=%0d issued while Busy", bus.MDOp);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic test_reset();
    reset = 1'b0;
    drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
    #2;
    checks++; if (bus.Busy !== 1'b0)   begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.HI !== 32'd0)    begin errors++; $display("[TB] FAIL reset_hi got=%h exp=0", bus.HI); end
    checks++; if (bus.LO !== 32'd0)    begin errors++; $display("[TB] FAIL reset_lo got=%h exp=0", bus.LO); end
    checks++; if (bus.MDOut !== 32'd0) begin errors++; $display("[TB] FAIL reset_mdout got=%h exp=0", bus.MDOut); end
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int n;
    drive(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    #1;
    checks++; if (bus.Start !== 1'b1) begin errors++; $display("[TB] FAIL mult_start got=%b exp=1", bus.Start); end
    model_apply(MD_MULT, 32'hFFFFFFFE, 32'd3);
    tick();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    checks++; if (n !== MULT_N)          begin errors++; $display("[TB] FAIL mult_busy_len got=%0d exp=%0d", n, MULT_N); end
    checks++; if (bus.HI !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi got=%h exp=ffffffff", bus.HI); end
    checks++; if (bus.LO !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo got=%h exp=fffffffa", bus.LO); end
    drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
    #1;
    checks++; if (bus.MDOut !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mfhi got=%h exp=ffffffff", bus.MDOut); end
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    tick();
  endtask

  task automatic test_div();
    int n;
    logic [3:0]  ops [3] = '{MD_DIV, MD_DIVU, MD_DIV};
    logic [31:0] as  [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFFFFFF};
    logic [31:0] eHi [3] = '{32'hFFFFFFFF, 32'd1, 32'd0};
    logic [31:0] eLo [3] = '{32'hFFFFFFFD, 32'h7FFFFFFC, 32'h80000000};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], as[i], bs[i], 1'b0);
      model_apply(ops[i], as[i], bs[i]);
      tick();
      drive(MD_NONE, 32'd0, 32'd0, 1'b0);
      wait_idle(n);
      checks++; if (n !== DIV_N)       begin errors++; $display("[TB] FAIL div%0d_busy_len got=%0d exp=%0d", i, n, DIV_N); end
      checks++; if (bus.HI !== eHi[i]) begin errors++; $display("[TB] FAIL div%0d_hi got=%h exp=%h", i, bus.HI, eHi[i]); end
      checks++; if (bus.LO !== eLo[i]) begin errors++; $display("[TB] FAIL div%0d_lo got=%h exp=%h", i, bus.LO, eLo[i]); end
    end
  endtask

  task automatic test_req();
    write_hilo(32'h1111, 32'h2222);
    drive(MD_MULT, 32'd5, 32'd5, 1'b1);
    #1;
    checks++; if (bus.Start !== 1'b0) begin errors++; $display("[TB] FAIL req_start got=%b exp=0", bus.Start); end
    tick();
    checks++; if (bus.Busy !== 1'b0)   begin errors++; $display("[TB] FAIL req_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.HI !== 32'h1111) begin errors++; $display("[TB] FAIL req_hi got=%h exp=00001111", bus.HI); end
    drive(MD_MTLO, 32'h1234, 32'd0, 1'b1);
    tick();
    checks++; if (bus.LO !== 32'h2222) begin errors++; $display("[TB] FAIL req_mtlo got=%h exp=00002222", bus.LO); end
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_div_zero();
    int n;
    write_hilo(32'hAAAA, 32'h5555);
    drive(MD_DIVU, 32'd9, 32'd0, 1'b0);
    #1;
    checks++; if (bus.Start !== 1'b1) begin errors++; $display("[TB] FAIL dz_start got=%b exp=1", bus.Start); end
    tick();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    checks++; if (n !== DIV_N)         begin errors++; $display("[TB] FAIL dz_busy_len got=%0d exp=%0d", n, DIV_N); end
    checks++; if (bus.HI !== 32'hAAAA) begin errors++; $display("[TB] FAIL dz_hi got=%h exp=0000aaaa", bus.HI); end
    checks++; if (bus.LO !== 32'h5555) begin errors++; $display("[TB] FAIL dz_lo got=%h exp=00005555", bus.LO); end
  endtask

  task automatic test_reset_mid_op();
    write_hilo(32'h33, 32'h44);
    drive(MD_MULT, 32'd7, 32'd9, 1'b0);
    tick();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    checks++; if (bus.Busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_busy_before got=%b exp=1", bus.Busy); end
    #1 reset = 1'b0;
    #1;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", bus.Busy); end
    checks++; if (bus.HI !== 32'd0)  begin errors++; $display("[TB] FAIL rst_mid_hi got=%h exp=0", bus.HI); end
    checks++; if (bus.LO !== 32'd0)  begin errors++; $display("[TB] FAIL rst_mid_lo got=%h exp=0", bus.LO); end
    mHi = 32'd0;
    mLo = 32'd0;
    #3 reset = 1'b1;
    tick();
    drive(MD_MTLO, 32'd7, 32'd0, 1'b0);
    tick();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    mLo = 32'd7;
    checks++; if (bus.LO !== 32'd7) begin errors++; $display("[TB] FAIL rst_mtlo got=%h exp=7", bus.LO); end
    repeat (MULT_N + 1) tick();
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("[TB] FAIL rst_discard_hi got=%h exp=0", bus.HI); end
  endtask

  task automatic test_madd();
    int n;
    write_hilo(32'd0, 32'hFFFFFFFF);
    drive(MD_MADDU, 32'd1, 32'd1, 1'b0);
    #1;
    checks++; if (bus.Start !== maddEn) begin errors++; $display("[TB] FAIL maddu_start got=%b exp=%b", bus.Start, maddEn); end
    model_apply(MD_MADDU, 32'd1, 32'd1);
    tick();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    checks++; if (n !== (maddEn ? MULT_N : 0)) begin errors++; $display("[TB] FAIL maddu_busy_len got=%0d exp=%0d", n, maddEn ? MULT_N : 0); end
    checks++; if (bus.HI !== (maddEn ? 32'd1 : 32'd0))        begin errors++; $display("[TB] FAIL maddu_hi got=%h", bus.HI); end
    checks++; if (bus.LO !== (maddEn ? 32'd0 : 32'hFFFFFFFF)) begin errors++; $display("[TB] FAIL maddu_lo got=%h", bus.LO); end
  endtask

  task automatic test_back_to_back();
    int n;
    drive(MD_MULTU, 32'h10000, 32'h10000, 1'b0);
    model_apply(MD_MULTU, 32'h10000, 32'h10000);
    tick();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    drive(MD_DIVU, 32'd100, 32'd7, 1'b0);
    #1;
    checks++; if (bus.Start !== 1'b1) begin errors++; $display("[TB] FAIL b2b_start got=%b exp=1", bus.Start); end
    checks++; if (bus.HI !== 32'd1)   begin errors++; $display("[TB] FAIL b2b_hi1 got=%h exp=1", bus.HI); end
    model_apply(MD_DIVU, 32'd100, 32'd7);
    tick();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
    #1;
    checks++; if (n !== DIV_N)           begin errors++; $display("[TB] FAIL b2b_busy_len got=%0d exp=%0d", n, DIV_N); end
    checks++; if (bus.MDOut !== 32'd14)  begin errors++; $display("[TB] FAIL b2b_mflo got=%h exp=0000000e", bus.MDOut); end
    checks++; if (bus.HI !== 32'd2)      begin errors++; $display("[TB] FAIL b2b_hi2 got=%h exp=2", bus.HI); end
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    int          n;
    bit          req;
    bit          expStart;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  pool [9] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, MD_NONE};
    for (int i = 0; i < 40; i++) begin
      op = pool[$urandom_range(0, 8)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2:       b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      req = ($urandom_range(0, 4) == 0);
      expStart = launches(op) && !req;
      drive(op, a, b, req);
      #1;
      checks++; if (bus.Start !== expStart) begin errors++; $display("[TB] FAIL rand%0d_start op=%0d got=%b exp=%b", i, op, bus.Start, expStart); end
      if (!req) model_apply(op, a, b);
      tick();
      drive(MD_NONE, 32'd0, 32'd0, 1'b0);
      wait_idle(n);
      checks++; if (n !== (expStart ? op_cycles(op) : 0)) begin errors++; $display("[TB] FAIL rand%0d_busy_len op=%0d got=%0d", i, op, n); end
      checks++; if (bus.HI !== mHi) begin errors++; $display("[TB] FAIL rand%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, bus.HI, mHi); end
      checks++; if (bus.LO !== mLo) begin errors++; $display("[TB] FAIL rand%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, bus.LO, mLo); end
      drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
      #1;
      checks++; if (bus.MDOut !== mLo) begin errors++; $display("[TB] FAIL rand%0d_mflo got=%h exp=%h", i, bus.MDOut, mLo); end
      drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    end
  endtask

  initial begin
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
    test_reset();
    test_mult();
    test_div();
    test_req();
    test_div_zero();
    test_reset_mid_op();
    test_madd();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_core.md
Name: mdu_core

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Responder side of the Start/Busy handshake that the hazard/stall controller consumes: it generates Start and Busy and owns the HI/LO registers.
- Executes mult/multu/div/divu with fixed multi-cycle latency, mthi/mtlo writes, and mfhi/mflo reads.
- Honours the CP0 exception request (Req) so an E-stage instruction flushed by an exception leaves no architectural effect.

Parameters:
- MULT_CYCLES, 5, Busy-cycle count for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10, Busy-cycle count for div/divu; legal range 1..15.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Req  in  1  exception/interrupt flush for the current E-stage instruction
- MDOp  in  4  operation code of the E-stage instruction (package encoding)
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- Start  out  1  combinational; high when the E-stage instruction launches an mult/div op this cycle
- Busy  out  1  registered; high while an op is in flight
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register
- MDOut  out  32  combinational read result for mfhi/mflo

Behaviour:
- Reset (async, reset=0): HI=0, LO=0, Busy=0, counter=0, state=IDLE, operand/result latches=0. Start and MDOut follow their equations.
- Start = (MDOp in {MULT, MULTU, DIV, DIVU[, MADD, MADDU]}) & ~Req & ~Busy.
- States: IDLE and BUSY.
- IDLE to BUSY on a clk edge with Start=1:
  - Compute the 64-bit result from the A/B present in that cycle and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from the next cycle.
- In BUSY, counter decrements each edge. On the edge where counter==1:
  - HI/LO take pending values.
  - Busy=0.
  - State returns to IDLE.
  - Busy is therefore high for exactly N cycles, and HI/LO are visible the first cycle Busy is low.
- Arithmetic:
  - mult: signed 32x32 to 64, {HI,LO}=product.
  - multu: unsigned 32x32 to 64, {HI,LO}=product.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- div boundaries:
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divisor 0: the op still occupies Busy for DIV_CYCLES, but HI/LO are left unchanged.
- MTHI/MTLO: HI<=A (resp. LO<=A) at the edge, only when ~Req & ~Busy. No Busy.
- MFHI/MFLO: MDOut=HI (resp. LO) combinationally. MDOut=0 for all other ops.
- Req=1: suppresses Start and mt* in that cycle; no state change for the E-stage op.
  - An op already in BUSY belongs to an older committed instruction and runs to completion regardless of Req.
- MDOp of any mult/div/mt* class arriving while Busy=1 is ignored; the hazard unit guarantees this never happens and the bench flags it as a protocol error.
- Reset asserted mid-operation: immediate return to the reset state; the pending result is discarded.

Optional Feature:
- MDU_MADD_EN defined:
  - MADD (signed) and MADDU (unsigned) are legal and raise Start.
  - After MULT_CYCLES, {HI,LO} <= {HI,LO} + product, modulo 2^64.
  - The accumulate base is the HI/LO value at retire, so a preceding mthi/mtlo is included.
- MDU_MADD_EN undefined: MADD/MADDU codes are treated as no-ops (no Start, no write).

Decomposition:
- Shared package/header (alongside the existing pipeline defines):
  - MDOp codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10.
  - State encodings IDLE/BUSY.
- One sub-module, mdu_arith: purely combinational. Takes MDOp, A and B; returns the 64-bit {hi,lo} result and a div_by_zero flag.
- mdu_core holds the FSM, counter, latches and HI/LO.

Test Plan:
1. mult: A=0xFFFFFFFE (-2), B=3, Start pulse
   - Start=1 that cycle; Busy=1 for cycles 1..5.
   - Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi MDOut=0xFFFFFFFF.
2. div: A=-7 (0xFFFFFFF9), B=2
   - Busy for 10 cycles.
   - Then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
   - divu with the same operands: LO=0x7FFFFFFC, HI=1.
3. Req=1 with MDOp=MULT, A=B=5
   - Start=0, Busy stays 0, HI/LO unchanged.
   - Repeat with MDOp=MTLO, A=0x1234: LO unchanged.
4. Start divu with A=9, B=0
   - Busy 10 cycles; HI/LO keep their prior values 0xAAAA/0x5555.
5. Reset mid-op: assert reset=0 in the 3rd Busy cycle of a mult
   - Busy=0, HI=LO=0 immediately, without waiting for a clock edge.
   - After release, mtlo A=7 gives LO=7 next cycle.
6. MDU_MADD_EN on: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1
   - After 5 Busy cycles: HI=1, LO=0.
   - With the macro off, the same stimulus gives Start=0 and no change.
